if_fetch_queue: RTL and testbench

- Parametrised successor to the single-cycle fetch stage.
- Owns the PC, issues word reads to an external synchronous instruction memory (1-cycle read latency), and buffers returned instructions with their PC in a FQ_DEPTH-entry FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes the queue and discards any in-flight read.

---
 rtl/if_fetch_queue_if.sv | 26 ++
 rtl/if_fetch_queue.sv | 91 +++++++++
 tb/tb_if_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory read port, decode handshake and redirect.
// The fetch unit uses the master view; memory/decode/branch logic uses the slave view.
interface if_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic [31:0]     i_imem_rdata;
    logic            o_inst_valid;
    logic            i_inst_ready;
    logic [31:0]     o_inst;
    logic [XLEN-1:0] o_inst_pc;
    logic [XLEN-1:0] o_inst_pc4;

    modport master (
        input  i_redirect, i_redirect_pc, i_imem_rdata, i_inst_ready,
        output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_inst_pc4
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_imem_rdata, i_inst_ready,
        input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_inst_pc4
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage with PC ownership, 1-cycle-latency imem reads and an FQ_DEPTH-entry
// instruction queue toward decode. FQ_DEPTH must be a power of two, >= 2.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    if_fetch_queue_if.master     bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  fetch_pc;
    logic             inflight;
    logic [XLEN-1:0]  inflight_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_inst [FQ_DEPTH];
    logic [XLEN-1:0]  q_pc   [FQ_DEPTH];

    logic             redirect;
    logic [XLEN-1:0]  redirect_tgt;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   credit_used;

    assign redirect     = bus.i_redirect;
    assign redirect_tgt = bus.i_redirect_pc & ~XLEN'(3);

    assign bus.o_inst_valid = i_rstn & (count != '0) & ~redirect;
    assign pop              = bus.o_inst_valid & bus.i_inst_ready;

    // Slots already promised: queued entries plus the read in flight, minus the
    // one leaving this cycle. Using pop here keeps a full-rate stream at depth 2.
    assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue       = i_rstn & ~redirect & (credit_used < (CNT_W+1)'(FQ_DEPTH));
    assign push        = inflight & ~redirect;

    assign bus.o_imem_req  = issue;
    assign bus.o_imem_addr = fetch_pc;

    assign bus.o_inst     = i_rstn ? q_inst[rd_ptr] : '0;
    assign bus.o_inst_pc  = i_rstn ? q_pc[rd_ptr]   : '0;
    assign bus.o_inst_pc4 = i_rstn ? (q_pc[rd_ptr] + XLEN'(4)) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_tgt;
            inflight <= 1'b0;
            rd_ptr   <= wr_ptr;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Datapath registers carry no reset; the control state above qualifies them.
    always_ff @(posedge i_clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
        if (i_rstn && push) begin
            q_inst[wr_ptr] <= bus.i_imem_rdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(push && (count == CNT_W'(FQ_DEPTH))));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, back-pressure, redirects,
// PC wrap and mid-stream reset against a word-indexed instruction memory model.
module tb_if_fetch_queue;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(32)) bus();

    if_fetch_queue #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .FQ_DEPTH(2)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        if (bus.o_imem_req) bus.i_imem_rdata <= mem_word(bus.o_imem_addr);
    end

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cyc(input logic rn, input logic rdy, input logic red, input logic [31:0] rpc);
        @(negedge clk);
        rstn              = rn;
        bus.i_inst_ready  = rdy;
        bus.i_redirect    = red;
        bus.i_redirect_pc = rpc;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl cyc %0d: req=%b valid=%b, expected 0 0", i, bus.o_imem_req, bus.o_inst_valid);
            end
            checks++;
            if (bus.o_inst !== 32'h0 || bus.o_inst_pc !== 32'h0 || bus.o_inst_pc4 !== 32'h0) begin
                errors++;
                $display("FAIL reset_data cyc %0d: inst=%h pc=%h pc4=%h, expected all 0", i, bus.o_inst, bus.o_inst_pc, bus.o_inst_pc4);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_req cyc %0d: req=%b addr=%h, expected 1 %h", i, bus.o_imem_req, bus.o_imem_addr, 32'(4 * i));
            end
            checks++;
            if (i < 2) begin
                if (bus.o_inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early_valid cyc %0d: valid=%b, expected 0", i, bus.o_inst_valid);
                end
            end else begin
                epc = 32'(4 * (i - 2));
                if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== mem_word(epc) ||
                    bus.o_inst_pc !== epc || bus.o_inst_pc4 !== epc + 32'd4) begin
                    errors++;
                    $display("FAIL stream_head cyc %0d: valid=%b inst=%h pc=%h pc4=%h, expected 1 %h %h %h",
                             i, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, bus.o_inst_pc4, mem_word(epc), epc, epc + 32'd4);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] epc;
        for (int s = 0; s < 6; s++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h20) begin
                errors++;
                $display("FAIL stall cyc %0d: req=%b valid=%b pc=%h, expected 0 1 00000020", s, bus.o_imem_req, bus.o_inst_valid, bus.o_inst_pc);
            end
        end
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            epc = 32'h20 + 32'(4 * j);
            checks++;
            if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== epc || bus.o_inst !== mem_word(epc)) begin
                errors++;
                $display("FAIL resume_head cyc %0d: valid=%b pc=%h inst=%h, expected 1 %h %h", j, bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, epc, mem_word(epc));
            end
            checks++;
            if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== epc + 32'd8) begin
                errors++;
                $display("FAIL resume_req cyc %0d: req=%b addr=%h, expected 1 %h", j, bus.o_imem_req, bus.o_imem_addr, epc + 32'd8);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_pc !== 32'h0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL redir_setup: pc=%h req=%b addr=%h, expected 0 1 8", bus.o_inst_pc, bus.o_imem_req, bus.o_imem_addr);
        end
        // Queue holds 0x4, read of 0x8 in flight, decode ready: redirect now.
        cyc(1'b1, 1'b1, 1'b1, 32'h40);
        checks++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle: valid=%b req=%b, expected 0 0", bus.o_inst_valid, bus.o_imem_req);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL redir_e1: valid=%b req=%b addr=%h, expected 0 1 40", bus.o_inst_valid, bus.o_imem_req, bus.o_imem_addr);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_imem_addr !== 32'h44) begin
            errors++;
            $display("FAIL redir_e2: valid=%b addr=%h, expected 0 44", bus.o_inst_valid, bus.o_imem_addr);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h40 || bus.o_inst !== 32'h1000_0010 || bus.o_inst_pc4 !== 32'h44) begin
            errors++;
            $display("FAIL redir_target: valid=%b pc=%h inst=%h pc4=%h, expected 1 40 10000010 44", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, bus.o_inst_pc4);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h44) begin
            errors++;
            $display("FAIL redir_next: valid=%b pc=%h, expected 1 44", bus.o_inst_valid, bus.o_inst_pc);
        end
    endtask

    task automatic test_redirect_unaligned();
        cyc(1'b1, 1'b1, 1'b1, 32'h43);
        checks++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL unal_cycle: valid=%b req=%b, expected 0 0", bus.o_inst_valid, bus.o_imem_req);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL unal_addr: req=%b addr=%h, expected 1 40", bus.o_imem_req, bus.o_imem_addr);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h40 || bus.o_inst !== 32'h1000_0010) begin
            errors++;
            $display("FAIL unal_head: valid=%b pc=%h inst=%h, expected 1 40 10000010", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b1, 1'b1, 32'h100);
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        checks++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b req=%b, expected 0 0", bus.o_inst_valid, bus.o_imem_req);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h200 || bus.o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_addr: req=%b addr=%h valid=%b, expected 1 200 0", bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h200 || bus.o_inst !== 32'h1000_0080) begin
            errors++;
            $display("FAIL b2b_head: valid=%b pc=%h inst=%h, expected 1 200 10000080", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst);
        end
    endtask

    task automatic test_wrap();
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr0: req=%b addr=%h, expected 1 fffffffc", bus.o_imem_req, bus.o_imem_addr);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1: req=%b addr=%h, expected 1 0", bus.o_imem_req, bus.o_imem_addr);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'hFFFF_FFFC || bus.o_inst !== 32'h4FFF_FFFF || bus.o_inst_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_head0: valid=%b pc=%h inst=%h pc4=%h, expected 1 fffffffc 4fffffff 0", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, bus.o_inst_pc4);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h0 || bus.o_inst !== 32'h1000_0000 || bus.o_inst_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_head1: valid=%b pc=%h inst=%h pc4=%h, expected 1 0 10000000 4", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, bus.o_inst_pc4);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: req=%b valid=%b, expected 0 1", bus.o_imem_req, bus.o_inst_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b0 || bus.o_inst !== 32'h0 || bus.o_inst_pc !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset cyc %0d: req=%b valid=%b inst=%h pc=%h, expected 0 0 0 0", i, bus.o_imem_req, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0 || bus.o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart: req=%b addr=%h valid=%b, expected 1 0 0", bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_imem_addr !== 32'h4 || bus.o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_second: addr=%h valid=%b, expected 4 0", bus.o_imem_addr, bus.o_inst_valid);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h0 || bus.o_inst !== 32'h1000_0000) begin
            errors++;
            $display("FAIL mid_head: valid=%b pc=%h inst=%h, expected 1 0 10000000", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst);
        end
    endtask

    initial begin
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        bus.i_inst_ready  = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_unaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
